// File: rtl/piezo_effect_sequencer_pkg.sv
// Shared types and defaults for the piezo effect sequencer.
package piezo_pkg;

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  localparam int DIV_W_DEF = 16;
  localparam int DUR_W_DEF = 10;
  localparam int REP_W_DEF = 3;

  // Channel-index width; a single channel still needs one bit for active_ch.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piezo_effect_sequencer_if.sv
// Game-logic <-> sequencer bundle. Per-channel fields are packed so that
// channel i occupies bits [i*W +: W] of the flattened vector.
// The repeat field is named repeat_n because "repeat" is a reserved word.
interface piezo_effect_sequencer_if
  import piezo_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int DIV_W = DIV_W_DEF,
  parameter int DUR_W = DUR_W_DEF,
  parameter int REP_W = REP_W_DEF
);
  logic                             tick;
  logic [N_CH-1:0]                  trig;
  logic [N_CH-1:0][DIV_W-1:0]       half_period;
  logic [N_CH-1:0][DUR_W-1:0]       duration;
  logic [N_CH-1:0][REP_W-1:0]       repeat_n;
  logic                             mute;
  logic                             piezoout;
  logic                             busy;
  logic [ch_w(N_CH)-1:0]            active_ch;

  modport master (output tick, trig, half_period, duration, repeat_n, mute,
                  input  piezoout, busy, active_ch);
  modport slave  (input  tick, trig, half_period, duration, repeat_n, mute,
                  output piezoout, busy, active_ch);
endinterface

// File: rtl/piezo_effect_sequencer_tone_gen.sv
// Divider + toggle flop shared by all channels. 'tone' is the flop's next
// value, so the caller's registered output changes on the same edge as the
// FSM enters TONE and the first TONE cycle is already high.
module piezo_tone_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic [DIV_W-1:0] half_period,
  output logic             tone
);
  logic [DIV_W-1:0] cnt, cnt_d;
  logic             tq, tq_d;

  // Next divider/toggle state: restart wins, idle forces low, hp=0 stays silent.
  always_comb begin
    cnt_d = cnt;
    tq_d  = tq;
    if (restart) begin
      cnt_d = '0;
      tq_d  = (half_period != '0);
    end else if (en) begin
      if (half_period == '0) begin
        tq_d = 1'b0;
      end else if (cnt == half_period - DIV_W'(1)) begin
        cnt_d = '0;
        tq_d  = ~tq;
      end else begin
        cnt_d = cnt + DIV_W'(1);
      end
    end else begin
      cnt_d = '0;
      tq_d  = 1'b0;
    end
  end

  // Divider and toggle registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      tq  <= 1'b0;
    end else begin
      cnt <= cnt_d;
      tq  <= tq_d;
    end
  end

  assign tone = tq_d;
endmodule

// File: rtl/piezo_effect_sequencer.sv
// N_CH-channel fixed-priority piezo effect sequencer (IDLE/TONE/GAP).
// Optional: define PIEZO_PREEMPT_EN to let a higher-priority request abort
// the running burst.
module piezo_effect_sequencer
  import piezo_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int DIV_W = DIV_W_DEF,
  parameter int DUR_W = DUR_W_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  piezo_effect_sequencer_if.slave bus
);
  localparam int CW = ch_w(N_CH);
  localparam logic [N_CH-1:0] CH_ONE = N_CH'(1);

  state_t            state;
  logic [N_CH-1:0]   pending, req, clr_mask;
  logic [CW-1:0]     sel_idx, act_q;
  logic              any_req, busy_q, pz_q;
  logic [DIV_W-1:0]  hp_q, hp_sel, hp_in;
  logic [DUR_W-1:0]  dur_q, dur_sel, dur_cnt, dur_inc;
  logic [REP_W-1:0]  reps_left, rep_sel;
  logic              seg_done, preempt, go, go_ok, restart, tone_en, tone_nxt;

  assign req = pending | bus.trig;

  // Lowest-index requester wins.
  always_comb begin
    sel_idx = '0;
    any_req = 1'b0;
    for (int i = N_CH-1; i >= 0; i--) begin
      if (req[i]) begin
        sel_idx = CW'(i);
        any_req = 1'b1;
      end
    end
  end

  assign hp_sel  = bus.half_period[sel_idx];
  assign dur_sel = bus.duration[sel_idx];
  assign rep_sel = bus.repeat_n[sel_idx];

  assign dur_inc  = dur_cnt + DUR_W'(1);
  assign seg_done = bus.tick && (dur_inc == dur_q);

`ifdef PIEZO_PREEMPT_EN
  assign preempt = (state != IDLE) && any_req && (sel_idx < act_q);
`else
  assign preempt = 1'b0;
`endif

  // Arbitrate from IDLE, straight out of a finished last burst, or on preemption.
  assign go       = any_req && ((state == IDLE) ||
                                (state == TONE && seg_done && reps_left == '0) ||
                                preempt);
  assign go_ok    = go && (dur_sel != '0);
  assign clr_mask = go ? (CH_ONE << sel_idx) : '0;
  assign restart  = go_ok || (state == GAP && seg_done);
  assign tone_en  = (state == TONE) && !seg_done && !go;
  assign hp_in    = go_ok ? hp_sel : hp_q;

  piezo_tone_gen #(.DIV_W(DIV_W)) u_tone (
    .clk         (clk),
    .rst         (rst),
    .en          (tone_en),
    .restart     (restart),
    .half_period (hp_in),
    .tone        (tone_nxt)
  );

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      act_q     <= '0;
      busy_q    <= 1'b0;
      pz_q      <= 1'b0;
      hp_q      <= '0;
      dur_q     <= '0;
      dur_cnt   <= '0;
      reps_left <= '0;
    end else begin
      pending <= req & ~clr_mask;
      pz_q    <= tone_nxt & ~bus.mute;
      if (go) begin
        dur_cnt <= '0;
        if (go_ok) begin
          state     <= TONE;
          busy_q    <= 1'b1;
          act_q     <= sel_idx;
          hp_q      <= hp_sel;
          dur_q     <= dur_sel;
          reps_left <= rep_sel;
        end else begin
          // zero-length request is dropped
          state  <= IDLE;
          busy_q <= 1'b0;
          act_q  <= '0;
        end
      end else begin
        case (state)
          TONE: if (bus.tick) begin
            if (seg_done) begin
              dur_cnt <= '0;
              if (reps_left != '0) begin
                reps_left <= reps_left - REP_W'(1);
                state     <= GAP;
              end else begin
                state  <= IDLE;
                busy_q <= 1'b0;
                act_q  <= '0;
              end
            end else begin
              dur_cnt <= dur_inc;
            end
          end
          GAP: if (bus.tick) begin
            if (seg_done) begin
              dur_cnt <= '0;
              state   <= TONE;
            end else begin
              dur_cnt <= dur_inc;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.piezoout  = pz_q;
  assign bus.busy      = busy_q;
  assign bus.active_ch = act_q;
endmodule

// File: tb/tb_piezo_effect_sequencer.sv
// Directed bench for piezo_effect_sequencer; channel start order is
// checked against a scoreboard queue filled as triggers are driven.
module tb_piezo_effect_sequencer;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int UW = 10;
  localparam int RW = 3;
  localparam int TP = 20;

  logic clk, rst;
  int   checks = 0, failures = 0;
  int   tcnt = 0;
  int   exp_q[$];
  logic prev_busy = 1'b0;
  int   prev_ch = 0;

  piezo_effect_sequencer_if #(.N_CH(N), .DIV_W(DW), .DUR_W(UW), .REP_W(RW)) bus ();

  piezo_effect_sequencer #(.N_CH(N), .DIV_W(DW), .DUR_W(UW), .REP_W(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, scoreboard start detection, then drive tick.
  task automatic cyc();
    int e;
    @(negedge clk);
    bus.trig = '0;
    if (!rst) begin
      if (bus.busy === 1'b1 && (!prev_busy || int'(bus.active_ch) != prev_ch)) begin
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_ch", 32'(bus.active_ch), 32'(e));
        end
      end
      prev_busy = bus.busy;
      prev_ch   = int'(bus.active_ch);
    end
    tcnt++;
    bus.tick = (tcnt % TP == 0);
  endtask

  task automatic set_ch(input int ch, input int hp, input int dur, input int rep);
    bus.half_period[ch] = DW'(hp);
    bus.duration[ch]    = UW'(dur);
    bus.repeat_n[ch]    = RW'(rep);
  endtask

  task automatic fire(input int ch);
    bus.trig[ch] = 1'b1;
    bus.tick     = 1'b0;
    tcnt         = 0;
    exp_q.push_back(ch);
  endtask

  // Single-channel burst model, with an optional mute window [mlo,mhi).
  task automatic run_burst(input int ch, input int hp, input int dur, input int rep,
                           input int mlo, input int mhi);
    int seglen, nseg, seg, off;
    logic eb, et, ep, mq;
    seglen = dur * TP;
    nseg   = 2 * rep + 1;
    mq     = 1'b0;
    bus.mute = 1'b0;
    set_ch(ch, hp, dur, rep);
    fire(ch);
    for (int k = 1; k <= nseg * seglen + 3; k++) begin
      cyc();
      seg = (k - 1) / seglen;
      off = k - 1 - seg * seglen;
      eb  = (seg < nseg);
      et  = eb && (seg % 2 == 0);
      ep  = et && (hp != 0) && ((off / hp) % 2 == 0) && !mq;
      chk("burst_busy", 32'(bus.busy), 32'(eb));
      chk("burst_pz", 32'(bus.piezoout), 32'(ep));
      chk("burst_ch", 32'(bus.active_ch), eb ? 32'(ch) : 32'd0);
      mq = (k >= mlo) && (k < mhi);
      bus.mute = mq;
    end
    bus.mute = 1'b0;
  endtask

  initial begin
    int seg, h;
    logic eb, ep;
    int ec;
    rst = 1'b1;
    bus.tick = 1'b0; bus.trig = '0; bus.mute = 1'b0;
    bus.half_period = '0; bus.duration = '0; bus.repeat_n = '0;
    @(negedge clk);
    chk("rst_pz", 32'(bus.piezoout), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ch", 32'(bus.active_ch), 32'd0);
    rst = 1'b0;
    repeat (3) cyc();

    // Reset in the middle of a high tone phase.
    set_ch(0, 4, 3, 0);
    fire(0);
    cyc(); cyc();
    chk("pre_rst_pz", 32'(bus.piezoout), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_pz", 32'(bus.piezoout), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_ch", 32'(bus.active_ch), 32'd0);
    #1 rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cyc();
      chk("post_rst_busy", 32'(bus.busy), 32'd0);
      chk("post_rst_pz", 32'(bus.piezoout), 32'd0);
    end

    // Basic tone, then repeats with gaps, then muted burst.
    run_burst(2, 3, 2, 0, 0, 0);
    run_burst(1, 2, 1, 2, 0, 0);
    run_burst(3, 5, 2, 0, 10, 25);

    // Simultaneous trig on 3 and 0: back-to-back with no idle cycle.
    set_ch(0, 2, 1, 0);
    set_ch(3, 3, 1, 0);
    fire(0);
    bus.trig[3] = 1'b1;
    exp_q.push_back(3);
    for (int k = 1; k <= 43; k++) begin
      cyc();
      seg = (k - 1) / TP;
      eb  = (k <= 2 * TP);
      h   = (seg == 0) ? 2 : 3;
      ec  = eb ? ((seg == 0) ? 0 : 3) : 0;
      ep  = eb && (((k - 1 - seg * TP) / h) % 2 == 0);
      chk("pair_busy", 32'(bus.busy), 32'(eb));
      chk("pair_ch", 32'(bus.active_ch), 32'(ec));
      chk("pair_pz", 32'(bus.piezoout), 32'(ep));
    end

    // Channel 0 request while channel 2 is in TONE.
    set_ch(2, 2, 2, 0);
    set_ch(0, 4, 1, 0);
    fire(2);
    for (int k = 1; k <= 65; k++) begin
      cyc();
`ifdef PIEZO_PREEMPT_EN
      eb = (k <= TP);
      ec = (k <= 10) ? 2 : 0;
`else
      eb = (k <= 3 * TP);
      ec = (k <= 2 * TP) ? 2 : 0;
`endif
      chk("prio_busy", 32'(bus.busy), 32'(eb));
      chk("prio_ch", 32'(bus.active_ch), 32'(ec));
      if (k == 10) begin
        bus.trig[0] = 1'b1;
        exp_q.push_back(0);
      end
    end

    // Zero-duration requests never start playback.
    set_ch(1, 3, 0, 1);
    bus.trig[1] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      cyc();
      chk("dur0_busy", 32'(bus.busy), 32'd0);
    end

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/piezo_effect_sequencer.md
Name: piezo_effect_sequencer

Overview:
Parametrised successor to the fixed bomb/defused/tick sound mixer. It arbitrates N_CH triggerable sound-effect channels onto one piezo output. Each channel has a run-time half-period (pitch), a burst duration in ticks and a repeat count. Channels are fixed-priority arbitrated, with a global mute. It sits between the game-logic FSMs and the piezo pin.

Parameters:
N_CH, 4, number of effect channels; channel 0 has the highest priority.
DIV_W, 16, width of the half-period field, in clk cycles.
DUR_W, 10, width of the burst/gap duration field, in tick strobes.
REP_W, 3, width of the repeat field; a burst plays rep+1 times.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
tick  input  1  one-cycle timebase strobe (e.g. 1 ms) for durations
trig  input  N_CH  one-cycle start pulse per channel
half_period  input  N_CH*DIV_W  per-channel tone half-period; channel i at bits [i*DIV_W +: DIV_W]
duration  input  N_CH*DUR_W  per-channel burst length, and gap length, in ticks
repeat  input  N_CH*REP_W  per-channel extra burst count
mute  input  1  forces piezoout low; sequencing continues
piezoout  output  1  registered square-wave drive
busy  output  1  FSM not IDLE
active_ch  output  $clog2(N_CH)  channel currently playing; 0 when idle

Behaviour:
- Async reset clears all state: piezoout=0, busy=0, active_ch=0, pending=0, FSM=IDLE, all counters=0.
- pending[i] is set when trig[i]=1 and cleared when channel i is selected.
  - Arbitration uses pending|trig, so a trig seen in IDLE on cycle t starts TONE on cycle t+1.
  - trig on the active channel sets pending again; the channel replays after it completes.
- Selection picks the lowest-index requesting channel.
  - On selection, half_period, duration and repeat for that channel are latched. Later input changes do not affect the running burst.
- FSM states: IDLE, TONE, GAP.
  - IDLE -> TONE when any channel is requesting. If the latched duration is 0, the request is dropped and the FSM stays IDLE.
  - TONE: the divider counts clk cycles. piezoout starts at 1 in the first TONE cycle and toggles every half_period cycles. If half_period=0, piezoout is held at 0 but timing still runs.
  - TONE: the duration counter increments on tick. When it reaches duration, go to GAP if reps_left>0 (decrement reps_left), else go to IDLE.
  - GAP: piezoout=0 for duration ticks, then return to TONE with the divider restarted and piezoout=1.
  - The first tick period is partial, so the real length lies between duration-1 and duration tick periods.
- piezoout = tone_bit & ~mute, registered. mute does not pause or reset counters.
- The divider and duration counters wrap only by reload, never by overflow. All arithmetic is unsigned at the field width.
- Simultaneous trig on several channels: the lowest index plays and the others stay pending, served in index order.
- Returning to IDLE and a new request in the same cycle: IDLE is skipped and the next channel starts TONE on the following cycle.

Optional Feature:
PIEZO_PREEMPT_EN
- Defined: while in TONE or GAP, a request from a channel with a lower index than active_ch aborts the current burst. The aborted channel's pending is not restored. The new channel starts TONE on the next cycle.
- Undefined: the current burst and its repeats always run to completion before re-arbitration.

Decomposition:
- Package piezo_pkg holds:
  - state enum {IDLE, TONE, GAP};
  - default widths DIV_W/DUR_W/REP_W;
  - a localparam function for the channel-index width, clog2 with a minimum of 1.
- Sub-module piezo_tone_gen: divider counter plus toggle flip-flop, with ports clk, rst, en, restart, half_period, tone. One instance is time-shared across channels.

Test Plan:
- Reset mid-TONE (rst pulse while piezoout=1) -> piezoout, busy and active_ch are 0 asynchronously; after release, no playback without a new trig.
- trig[2] with half_period=3, duration=2, repeat=0, tick every 20 cycles -> busy from the next cycle; piezoout period is 6 cycles (3 high/3 low), starting high; returns to IDLE after the 2nd tick.
- trig[1] with repeat=2, duration=1 -> 3 tone bursts separated by 1-tick silent gaps; active_ch=1 throughout; busy drops after the 3rd burst.
- trig[3] and trig[0] in the same cycle -> channel 0 plays first, then channel 3 with no IDLE cycle in between; active_ch goes 0 then 3.
- mute=1 during a burst with half_period=5 -> piezoout stays 0, busy and the burst end time are unchanged; after unmute, piezoout resumes in phase with the divider.
- trig[0] during channel 2's TONE -> with PIEZO_PREEMPT_EN, active_ch=0 next cycle and channel 2 is not replayed; without it, channel 0 starts only after channel 2 finishes. Separately, duration=0 on any channel -> busy never asserts.
